// File: rtl/pkt_filter_pkg.sv
// ---------------------------------------------------------------------------
// pkt_filter_pkg
// Shared definitions for the HPS-side frame transmitter (pkt_tx_avalon):
//   - Avalon-MM register word addresses
//   - bit positions inside the CTRL and STATUS registers
//   - transmitter state encoding
//   - small helpers that turn a byte length into beat count / empty value
// ---------------------------------------------------------------------------
package pkt_filter_pkg;

   // Register word addresses on the Avalon-MM slave
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_LEN    = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // CTRL register bit positions
   localparam int CTRL_GO      = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_IRQ_CLR = 2;
   localparam int CTRL_FLUSH   = 3;
   localparam int CTRL_ERR_CLR = 4;

   // STATUS register bit positions; the word count starts at STAT_COUNT_LSB
   localparam int STAT_BUSY      = 0;
   localparam int STAT_IRQ_PEND  = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_ERR       = 3;
   localparam int STAT_COUNT_LSB = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } tx_state_t;

   // Number of 32-bit beats needed to carry len bytes: ceil(len/4)
   function automatic logic [14:0] beats_for_len(input logic [15:0] len);
      return 15'((32'(len) + 32'd3) >> 2);
   endfunction

   // Unused bytes on the final beat: (4 - len%4) % 4, i.e. the two's
   // complement of the low two length bits
   function automatic logic [1:0] empty_for_len(input logic [1:0] len_lsb);
      return 2'(3'd4 - {1'b0, len_lsb});
   endfunction

endpackage

// File: rtl/pkt_tx_avalon_if.sv
// ---------------------------------------------------------------------------
// pkt_tx_avalon_if
// Bundles the Avalon-MM register slave and the Avalon-ST source of the frame
// transmitter.
//   avs_chipselect / avs_address / avs_write / avs_writedata / avs_read
//                      : register access from the HPS
//   avs_readdata       : registered read data, valid the cycle after avs_read
//   aso_data / aso_valid / aso_startofpacket / aso_endofpacket / aso_empty
//                      : 32-bit stream beat, first byte in [31:24]
//   aso_ready          : sink ready, readyLatency 0
// Modports:
//   slave  - the transmitter block itself
//   master - the HPS bridge plus downstream stream sink (or a testbench)
// ---------------------------------------------------------------------------
interface pkt_tx_avalon_if;

   logic        avs_chipselect;
   logic [1:0]  avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_read;
   logic [31:0] avs_readdata;

   logic [31:0] aso_data;
   logic        aso_valid;
   logic        aso_ready;
   logic        aso_startofpacket;
   logic        aso_endofpacket;
   logic [1:0]  aso_empty;

   modport slave (
      input  avs_chipselect,
      input  avs_address,
      input  avs_write,
      input  avs_writedata,
      input  avs_read,
      output avs_readdata,
      output aso_data,
      output aso_valid,
      input  aso_ready,
      output aso_startofpacket,
      output aso_endofpacket,
      output aso_empty
   );

   modport master (
      output avs_chipselect,
      output avs_address,
      output avs_write,
      output avs_writedata,
      output avs_read,
      input  avs_readdata,
      input  aso_data,
      input  aso_valid,
      output aso_ready,
      input  aso_startofpacket,
      input  aso_endofpacket,
      input  aso_empty
   );

endinterface

// File: rtl/pkt_tx_avalon_buf.sv
// ---------------------------------------------------------------------------
// pkt_tx_buf
// Frame buffer: simple dual-port RAM, BUF_DEPTH x 32, one write port and one
// registered read port. Contents are not reset; pointers and occupancy are
// tracked by the parent block.
//   clk     : system clock
//   wr_en   : write strobe
//   wr_addr : write word address
//   wr_data : write data
//   rd_addr : read word address, sampled every cycle
//   rd_data : word at rd_addr as of the previous edge
// ---------------------------------------------------------------------------
module pkt_tx_buf #(
   parameter int BUF_DEPTH = 512,
   parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data
);

   logic [31:0] mem [BUF_DEPTH];

   // Plain write port plus an always-enabled registered read; the parent
   // re-issues the same address during a stall so rd_data stays stable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pkt_tx_avalon.sv
// ---------------------------------------------------------------------------
// pkt_tx_avalon
// HPS-side frame transmitter. The HPS pushes a frame word by word into the
// DATA register, writes the byte length to LEN, then sets CTRL.GO. The frame
// leaves on a 32-bit Avalon-ST source with SOP/EOP/empty and, once the last
// beat is accepted, IRQ_PEND is raised (irq = IRQ_PEND & IRQ_EN).
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : pkt_tx_avalon_if.slave (Avalon-MM registers + Avalon-ST source)
//   irq    : level interrupt towards the f2h IRQ line
// ---------------------------------------------------------------------------
module pkt_tx_avalon
   import pkt_filter_pkg::*;
#(
   parameter int BUF_DEPTH = 512,
   parameter int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   pkt_tx_avalon_if.slave       bus,
   output logic                 irq
);

   localparam int PTR_W = $clog2(BUF_DEPTH);

   tx_state_t        state;
   tx_state_t        state_next;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_addr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] avail;
   logic [CNT_W-1:0] beat;
   logic [15:0]      len;
   logic [14:0]      frame_beats;
   logic             irq_en;
   logic             irq_pend;
   logic             ovf;
   logic             err;
   logic [31:0]      rd_data;
   logic [31:0]      status_word;

   logic             wr_acc;
   logic             rd_acc;
   logic             data_wr;
   logic             len_wr;
   logic             ctrl_wr;
   logic             idle;
   logic             sending;
   logic             full;
   logic             len_ok;
   logic             go_req;
   logic             go_accept;
   logic             go_reject;
   logic             push;
   logic             drop;
   logic             flush;
   logic             transfer;
   logic             last_beat;
   logic             frame_done;

   // Register decode; every access is qualified by chipselect
   assign wr_acc  = bus.avs_chipselect & bus.avs_write;
   assign rd_acc  = bus.avs_chipselect & bus.avs_read;
   assign data_wr = wr_acc & (bus.avs_address == REG_DATA);
   assign len_wr  = wr_acc & (bus.avs_address == REG_LEN);
   assign ctrl_wr = wr_acc & (bus.avs_address == REG_CTRL);

   assign idle    = (state == IDLE);
   assign sending = (state == SEND);

   // Buffer occupancy and the DATA-write outcome. Writes arriving while the
   // buffer is full, or while a frame is in flight, are dropped and flagged.
   assign full  = (32'(count) == BUF_DEPTH);
   assign push  = data_wr & idle & ~full;
   assign drop  = data_wr & (~idle | full);

   // FLUSH only acts in IDLE; a GO in the same write then sees an empty
   // buffer and is rejected rather than sending stale contents.
   assign flush = ctrl_wr & bus.avs_writedata[CTRL_FLUSH] & idle;
   assign avail = flush ? '0 : count;

   assign frame_beats = beats_for_len(len);
   assign len_ok      = (len != 16'd0) && (32'(len) <= 4 * BUF_DEPTH);
   assign go_req      = ctrl_wr & bus.avs_writedata[CTRL_GO];

   // Stream handshake bookkeeping
   assign transfer   = sending & bus.aso_ready;
   assign last_beat  = ((32'(beat) + 32'd1) == 32'(frame_beats));
   assign frame_done = transfer & last_beat;

   // The RAM read is issued one beat ahead: on a transfer we fetch the next
   // word so it lands on rd_data exactly when the next beat is presented,
   // and during a stall the same word is re-read so the beat holds steady.
   assign rd_addr = transfer ? rd_ptr + PTR_W'(1) : rd_ptr;

   pkt_tx_buf #(
      .BUF_DEPTH (BUF_DEPTH),
      .ADDR_W    (PTR_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (bus.avs_writedata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Next-state logic. LOAD exists only to cover the RAM read latency of
   // word 0, so the first beat appears two cycles after the GO write.
   always_comb begin
      state_next = state;
      go_accept  = 1'b0;
      go_reject  = 1'b0;
      case (state)
         IDLE: begin
            if (go_req) begin
               if (len_ok && (32'(avail) >= 32'(frame_beats))) begin
                  go_accept  = 1'b1;
                  state_next = LOAD;
               end else begin
                  go_reject  = 1'b1;
               end
            end
         end
         LOAD: begin
            state_next = SEND;
         end
         SEND: begin
            if (frame_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Buffer pointers, word count and beat index. A completed frame empties
   // the buffer outright, so any words loaded beyond LEN are discarded and
   // every new frame starts at address 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         beat   <= '0;
      end else if (frame_done || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         beat   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            count  <= count + CNT_W'(1);
         end
         if (transfer) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            beat   <= beat + CNT_W'(1);
         end
      end
   end

   // Software-visible registers and sticky flags. For IRQ_PEND and ERR the
   // set condition is written last so it wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         len      <= '0;
         irq_en   <= 1'b0;
         irq_pend <= 1'b0;
         ovf      <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (len_wr && idle) begin
            len <= bus.avs_writedata[15:0];
         end
         if (ctrl_wr) begin
            irq_en <= bus.avs_writedata[CTRL_IRQ_EN];
            if (bus.avs_writedata[CTRL_IRQ_CLR]) begin
               irq_pend <= 1'b0;
            end
            if (bus.avs_writedata[CTRL_ERR_CLR]) begin
               err <= 1'b0;
            end
         end
         if (frame_done) begin
            irq_pend <= 1'b1;
         end
         if (go_reject) begin
            err <= 1'b1;
         end
         if (flush) begin
            ovf <= 1'b0;
         end
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   // STATUS word assembled from the current (pre-write) register values
   always_comb begin
      status_word                              = '0;
      status_word[STAT_BUSY]                   = ~idle;
      status_word[STAT_IRQ_PEND]               = irq_pend;
      status_word[STAT_OVF]                    = ovf;
      status_word[STAT_ERR]                    = err;
      status_word[STAT_COUNT_LSB +: CNT_W]     = count;
   end

   // Registered read port; a read sees values from before any write that
   // lands on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.avs_readdata <= '0;
      end else if (rd_acc) begin
         case (bus.avs_address)
            REG_LEN:    bus.avs_readdata <= {16'b0, len};
            REG_CTRL:   bus.avs_readdata <= {30'b0, irq_en, 1'b0};
            REG_STATUS: bus.avs_readdata <= status_word;
            default:    bus.avs_readdata <= '0;
         endcase
      end
   end

   // Stream outputs are forced to zero outside SEND so the port is quiet
   // in IDLE/LOAD and immediately after a reset.
   assign bus.aso_valid         = sending;
   assign bus.aso_data          = sending ? rd_data : '0;
   assign bus.aso_startofpacket = sending & (beat == '0);
   assign bus.aso_endofpacket   = sending & last_beat;
   assign bus.aso_empty         = (sending && last_beat) ? empty_for_len(len[1:0]) : 2'b00;

   assign irq = irq_pend & irq_en;

   // go_accept is kept as a named decode of the accepted-GO condition
   logic unused_ok;
   assign unused_ok = go_accept;

endmodule

// File: tb/tb_pkt_tx_avalon.sv
// ---------------------------------------------------------------------------
// tb_pkt_tx_avalon
// Self-checking bench for pkt_tx_avalon. A transaction-level model (frame
// word queue, register/flag variables, expected-beat queue) follows the
// register writes the bench issues; a compare process checks the stream and
// irq every cycle, and the directed tests add hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_pkt_tx_avalon;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset;
   logic irq;

   pkt_tx_avalon_if bus();

   pkt_tx_avalon #(
      .BUF_DEPTH (DEPTH),
      .CNT_W     (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
   } beat_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          go_cyc   = -1;
   int          first_valid_cyc = -1;

   logic [31:0] m_buf[$];
   beat_t       exp_q[$];
   beat_t       act_log[$];
   logic [15:0] m_len      = '0;
   logic        m_irq_en   = 1'b0;
   logic        m_irq_pend = 1'b0;
   logic        m_ovf      = 1'b0;
   logic        m_err      = 1'b0;
   int          m_phase    = 0;     // 0 idle, 1 fetching first word, 2 streaming
   logic        model_live = 1'b0;
   logic [31:0] exp_rd     = '0;

   function automatic logic [63:0] pk(input beat_t b);
      return {28'b0, b.sop, b.eop, b.empty, b.data};
   endfunction

   task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Register read value the specification requires, from model state
   function automatic logic [31:0] predict(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd1: r = {16'b0, m_len};
         2'd2: r = {30'b0, m_irq_en, 1'b0};
         2'd3: begin
            r[0] = (m_phase != 0);
            r[1] = m_irq_pend;
            r[2] = m_ovf;
            r[3] = m_err;
            r[16 +: CW] = CW'(m_buf.size());
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Model: applies the register rules and frame progress at each edge
   always @(posedge clk) begin
      logic        busy_pre;
      logic        pend_set;
      logic [31:0] wd;
      int          nb;
      beat_t       b;
      if (reset) begin
         m_buf.delete();
         exp_q.delete();
         m_len = '0; m_irq_en = 0; m_irq_pend = 0; m_ovf = 0; m_err = 0;
         m_phase = 0; exp_rd = '0;
         model_live = 1'b1;
      end else if (model_live) begin
         busy_pre = (m_phase != 0);
         pend_set = 1'b0;
         wd = bus.avs_writedata;
         if (bus.avs_chipselect && bus.avs_read) exp_rd = predict(bus.avs_address);
         if (m_phase == 2 && bus.aso_valid && bus.aso_ready) begin
            b.data = bus.aso_data; b.sop = bus.aso_startofpacket;
            b.eop = bus.aso_endofpacket; b.empty = bus.aso_empty;
            act_log.push_back(b);
            if (exp_q.size() > 0) begin
               if (exp_q[0].eop) begin
                  m_phase = 0;
                  m_buf.delete();
                  pend_set = 1'b1;
               end
               void'(exp_q.pop_front());
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end
         if (bus.avs_chipselect && bus.avs_write) begin
            case (bus.avs_address)
               2'd0: if (busy_pre || m_buf.size() == DEPTH) m_ovf = 1'b1;
                     else m_buf.push_back(wd);
               2'd1: if (!busy_pre) m_len = wd[15:0];
               2'd2: begin
                  m_irq_en = wd[1];
                  if (wd[2]) m_irq_pend = 1'b0;
                  if (wd[4]) m_err = 1'b0;
                  if (!busy_pre) begin
                     if (wd[3]) begin m_buf.delete(); m_ovf = 1'b0; end
                     if (wd[0]) begin
                        nb = (int'(m_len) + 3) / 4;
                        if (m_len >= 1 && int'(m_len) <= 4 * DEPTH && m_buf.size() >= nb) begin
                           exp_q.delete();
                           for (int i = 0; i < nb; i++) begin
                              b.data  = m_buf[i];
                              b.sop   = (i == 0);
                              b.eop   = (i == nb - 1);
                              b.empty = (i == nb - 1) ? 2'((4 - int'(m_len) % 4) % 4) : 2'd0;
                              exp_q.push_back(b);
                           end
                           m_phase = 1;
                           go_cyc = cyc;
                           first_valid_cyc = -1;
                        end else begin
                           m_err = 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
         if (pend_set) m_irq_pend = 1'b1;
      end
      cyc++;
   end

   // Compare: stream and irq checked against the model on every cycle
   always @(negedge clk) begin
      if (model_live && !reset) begin
         checkOutput("aso_valid", bus.aso_valid, (m_phase == 2));
         checkOutput("irq", irq, m_irq_pend & m_irq_en);
         if (bus.aso_valid && m_phase == 2 && exp_q.size() > 0) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            checkOutput("beat", pk('{bus.aso_data, bus.aso_startofpacket,
                                     bus.aso_endofpacket, bus.aso_empty}), pk(exp_q[0]));
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.avs_chipselect = 1'b1; bus.avs_write = 1'b1;
      bus.avs_address = a; bus.avs_writedata = d;
      @(negedge clk);
      bus.avs_chipselect = 1'b0; bus.avs_write = 1'b0;
   endtask

   task automatic readReg(input logic [1:0] a, input string nm, input logic [31:0] lit);
      @(negedge clk);
      bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_address = a;
      @(negedge clk);
      bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0;
      checkOutput({nm, "_model"}, bus.avs_readdata, exp_rd);
      checkOutput(nm, bus.avs_readdata, lit);
   endtask

   task automatic waitFrameDone(input int limit);
      int n = 0;
      while (m_phase != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frame_done_in_time", (m_phase == 0), 1);
   endtask

   task automatic pulseReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] words3 [3];
      logic        rpat [6];
      words3 = '{32'h01020304, 32'h05060708, 32'h090A0B00};
      rpat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      reset = 1'b1;
      bus.avs_chipselect = 0; bus.avs_address = '0; bus.avs_write = 0;
      bus.avs_writedata = '0; bus.avs_read = 0; bus.aso_ready = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_valid", bus.aso_valid, 0);
      checkOutput("rst_irq", irq, 0);
      readReg(2'd3, "rst_status", 32'h0);
      readReg(2'd1, "rst_len", 32'h0);

      $display("[TB] test 1: basic frame");
      bus.aso_ready = 1'b1;
      act_log.delete();
      for (int i = 0; i < 3; i++) applyStimulus(2'd0, words3[i]);
      applyStimulus(2'd1, 32'd11);
      readReg(2'd1, "t1_len", 32'd11);
      applyStimulus(2'd2, 32'h3);
      waitFrameDone(20);
      checkOutput("t1_latency", first_valid_cyc - go_cyc, 2);
      checkOutput("t1_nbeats", act_log.size(), 3);
      if (act_log.size() == 3) begin
         checkOutput("t1_beat0", pk(act_log[0]), 64'h8_0102_0304);
         checkOutput("t1_beat1", pk(act_log[1]), 64'h0_0506_0708);
         checkOutput("t1_beat2", pk(act_log[2]), 64'h5_090A_0B00);
      end
      @(negedge clk);
      checkOutput("t1_irq", irq, 1);
      readReg(2'd3, "t1_status", 32'h2);
      readReg(2'd2, "t1_ctrl", 32'h2);

      $display("[TB] test 2: backpressure");
      applyStimulus(2'd2, 32'h6);
      bus.aso_ready = 1'b0;
      act_log.delete();
      for (int i = 0; i < 3; i++) applyStimulus(2'd0, words3[i]);
      applyStimulus(2'd1, 32'd11);
      applyStimulus(2'd2, 32'h3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.aso_ready = rpat[i];
      end
      bus.aso_ready = 1'b1;
      waitFrameDone(20);
      checkOutput("t2_nbeats", act_log.size(), 3);
      if (act_log.size() == 3) begin
         checkOutput("t2_beat0", pk(act_log[0]), 64'h8_0102_0304);
         checkOutput("t2_beat1", pk(act_log[1]), 64'h0_0506_0708);
         checkOutput("t2_beat2", pk(act_log[2]), 64'h5_090A_0B00);
      end
      readReg(2'd3, "t2_status", 32'h2);

      $display("[TB] test 3: rejected GO");
      applyStimulus(2'd2, 32'h4);
      applyStimulus(2'd0, 32'hCAFE0001);
      applyStimulus(2'd1, 32'd8);
      applyStimulus(2'd2, 32'h1);
      repeat (4) @(negedge clk);
      checkOutput("t3_valid", bus.aso_valid, 0);
      readReg(2'd3, "t3_status_err", 32'h0001_0008);
      applyStimulus(2'd2, 32'h10);
      readReg(2'd3, "t3_status_clr", 32'h0001_0000);
      applyStimulus(2'd2, 32'h8);
      readReg(2'd3, "t3_status_flush", 32'h0);

      $display("[TB] test 4: DATA write while busy");
      bus.aso_ready = 1'b0;
      act_log.delete();
      for (int i = 0; i < 4; i++) applyStimulus(2'd0, 32'hA0A0_0000 + 32'(i));
      applyStimulus(2'd1, 32'd16);
      applyStimulus(2'd2, 32'h1);
      repeat (2) @(negedge clk);
      applyStimulus(2'd0, 32'hDEADBEEF);
      readReg(2'd3, "t4_status_busy", 32'h0004_0005);
      bus.aso_ready = 1'b1;
      waitFrameDone(20);
      checkOutput("t4_nbeats", act_log.size(), 4);
      if (act_log.size() == 4) begin
         checkOutput("t4_beat0", pk(act_log[0]), 64'h8_A0A0_0000);
         checkOutput("t4_beat3", pk(act_log[3]), 64'h4_A0A0_0003);
      end
      readReg(2'd3, "t4_status_done", 32'h6);

      $display("[TB] test 5: reset mid-frame");
      applyStimulus(2'd2, 32'hA);
      act_log.delete();
      for (int i = 0; i < 4; i++) applyStimulus(2'd0, 32'hB0B0_0000 + 32'(i));
      applyStimulus(2'd1, 32'd16);
      applyStimulus(2'd2, 32'h3);
      n = 0;
      while (act_log.size() < 2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5_two_beats", act_log.size(), 2);
      pulseReset();
      checkOutput("t5_valid", bus.aso_valid, 0);
      checkOutput("t5_eop", bus.aso_endofpacket, 0);
      checkOutput("t5_irq", irq, 0);
      readReg(2'd3, "t5_status", 32'h0);
      readReg(2'd1, "t5_len", 32'h0);

      $display("[TB] test 6: full buffer");
      bus.aso_ready = 1'b0;
      act_log.delete();
      for (int i = 0; i <= DEPTH; i++) applyStimulus(2'd0, 32'h1000_0000 + 32'(i));
      readReg(2'd3, "t6_status_full", 32'h0010_0004);
      applyStimulus(2'd1, 32'(4 * DEPTH));
      applyStimulus(2'd2, 32'h1);
      bus.aso_ready = 1'b1;
      waitFrameDone(60);
      checkOutput("t6_nbeats", act_log.size(), DEPTH);
      if (act_log.size() == DEPTH) begin
         checkOutput("t6_first", pk(act_log[0]), 64'h8_1000_0000);
         checkOutput("t6_last", pk(act_log[DEPTH-1]), 64'h4_1000_000F);
      end
      readReg(2'd3, "t6_status_done", 32'h6);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pkt_tx_avalon.md
Name: pkt_tx_avalon

Overview:
- HPS-side frame transmitter; the egress counterpart to the packet-filter receive path.
- The HPS loads a frame word-by-word through an Avalon-MM slave, writes the byte length, then sets GO.
- The block emits the frame on a 32-bit Avalon-ST source with SOP/EOP/empty, then raises an interrupt on the soc_system f2h IRQ line.
- Lives inside soc_system as a Qsys component clocked from clk_clk.

Parameters:
BUF_DEPTH, 512, frame buffer depth in 32-bit words; power of two, at least 4
CNT_W, $clog2(BUF_DEPTH)+1, width of the word-count field

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
avs_chipselect  input  1  slave select
avs_address  input  2  word register address
avs_write  input  1  register write strobe
avs_writedata  input  32  write data
avs_read  input  1  register read strobe
avs_readdata  output  32  read data, read latency 1
aso_data  output  32  stream data; first byte in [31:24]
aso_valid  output  1  beat valid
aso_ready  input  1  sink ready, readyLatency 0
aso_startofpacket  output  1  first beat of frame
aso_endofpacket  output  1  last beat of frame
aso_empty  output  2  unused bytes on the EOP beat
irq  output  1  level interrupt = IRQ_PEND & IRQ_EN

Behaviour:
- Register map (an access is valid only when chipselect is high):
  - 0 DATA (W): push a word into the buffer.
  - 1 LEN (R/W): frame length in bytes, [15:0].
  - 2 CTRL (W): bit0 GO, bit1 IRQ_EN (stored), bit2 IRQ_CLR, bit3 FLUSH, bit4 ERR_CLR. Reads return {30'b0, IRQ_EN, 1'b0}.
  - 3 STATUS (R): bit0 BUSY, bit1 IRQ_PEND, bit2 OVF, bit3 ERR, [16+CNT_W-1:16] word count.
- Read latency: avs_readdata is registered and valid on the cycle after avs_read.
- Reset values: all outputs 0; LEN=0, IRQ_EN=0, all flags 0, buffer empty, state IDLE.
- States:
  - IDLE: accepts DATA, LEN, FLUSH and GO.
    - DATA write when count==BUF_DEPTH: word dropped, OVF set.
    - GO accepted only if 1<=LEN<=4*BUF_DEPTH and count>=ceil(LEN/4). Otherwise ERR is set and the state stays IDLE.
    - Accepted GO -> LOAD.
  - LOAD: one cycle for the RAM read of word 0 -> SEND. aso_valid is first high exactly 2 cycles after the GO write edge.
  - SEND:
    - aso_valid is held high; a beat transfers on valid&ready.
    - While valid && !ready, data, SOP, EOP and empty stay stable.
    - Prefetching keeps throughput at 1 beat/cycle while ready is high.
    - SOP on beat 0 only. EOP on beat ceil(LEN/4)-1. empty=(4-LEN%4)%4 on the EOP beat, 0 otherwise. A one-beat frame has SOP and EOP together.
    - After the EOP transfer -> IDLE on the next edge: aso_valid=0, IRQ_PEND=1, buffer cleared (words beyond LEN discarded).
  - BUSY = (state != IDLE).
- Writes during LOAD/SEND:
  - DATA: dropped, OVF set.
  - LEN and GO: ignored.
  - FLUSH: ignored.
  - IRQ_EN, IRQ_CLR, ERR_CLR: honoured.
- Flags: OVF is cleared by FLUSH. If IRQ_CLR is written in the same cycle a frame completes, the set wins.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Reset mid-frame: aso_valid=0 on the next cycle with no EOP; the buffer is emptied and all state returns to reset values.
- Word count is CNT_W bits wide and holds values 0..BUF_DEPTH. Pointers are log2(BUF_DEPTH) bits and wrap naturally.

Decomposition:
- Package pkt_filter_pkg:
  - register address localparams (REG_DATA=0, REG_LEN=1, REG_CTRL=2, REG_STATUS=3)
  - CTRL/STATUS bit-index localparams
  - tx_state_t enum {IDLE, LOAD, SEND}
- Sub-module pkt_tx_buf: simple dual-port RAM, BUF_DEPTH x 32, one write port, registered read, no reset on contents. Pointers and count live in pkt_tx_avalon.

Test Plan:
1. Basic frame: write 0x01020304, 0x05060708, 0x090A0B00; LEN=11; CTRL=0x3 with ready=1 -> 3 consecutive beats starting 2 cycles after GO; SOP on beat 0; EOP and empty=1 on beat 2; then irq=1; STATUS=0x2 with count 0.
2. Backpressure: same frame, ready pattern 1,0,0,1,0,1 -> data held stable while stalled; exactly 3 transfers in order; no duplicates.
3. Bad GO: 1 word loaded, LEN=8, GO -> aso_valid stays 0; STATUS ERR=1, BUSY=0; ERR_CLR clears it.
4. Busy write: GO a 4-word frame with ready=0, write DATA during SEND -> OVF=1; the emitted frame is unchanged; count=0 after EOP.
5. Reset mid-frame: assert reset after beat 1 transfers -> aso_valid=0 and irq=0 next cycle; STATUS reads 0.
6. Full buffer: BUF_DEPTH+1 DATA writes -> OVF=1, count=BUF_DEPTH; LEN=4*BUF_DEPTH, GO -> BUF_DEPTH beats with empty=0 on EOP.
